// File: rtl/rob_pkg.sv
// Shared constants and types for the reorder-buffer producer side.
package rob_pkg;

    localparam int ROB_DEPTH = 4;
    localparam int TAG_W     = 2;
    localparam int REG_AW    = 4;
    localparam int DATA_W    = 32;
    localparam int INSTR_W   = 32;
    localparam int NUM_REGS  = 1 << REG_AW;

    typedef struct packed {
        logic               alloc;
        logic               done;
        logic [INSTR_W-1:0] instr;
        logic [REG_AW-1:0]  dest;
        logic [DATA_W-1:0]  value;
    } rob_entry_t;

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] tag;
    } rename_entry_t;

    // Pointer advance; wraps naturally because ROB_DEPTH is a power of two.
    function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/rob_rename_table.sv
// Register rename table: maps each architectural register to its youngest
// in-flight ROB tag. A dispatch write to the same register as a commit clear
// overrides the clear, so the newer producer stays visible.
module rob_rename_table
    import rob_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_we_i,
    input  logic [REG_AW-1:0] disp_dest_i,
    input  logic [TAG_W-1:0]  disp_tag_i,
    input  logic              clr_we_i,
    input  logic [REG_AW-1:0] clr_reg_i,
    input  logic [REG_AW-1:0] src_reg_i,
    output logic              src_busy_o,
    output logic [TAG_W-1:0]  src_tag_o,
    input  logic [REG_AW-1:0] chk_reg_i,
    output logic              chk_busy_o,
    output logic [TAG_W-1:0]  chk_tag_o
);

    rename_entry_t rename_q [NUM_REGS];
    rename_entry_t rename_d [NUM_REGS];

    // Next-state: commit clear first, then dispatch write so it takes priority.
    always_comb begin
        rename_d = rename_q;
        if (clr_we_i) begin
            rename_d[clr_reg_i].busy = 1'b0;
        end
        if (disp_we_i) begin
            rename_d[disp_dest_i].busy = 1'b1;
            rename_d[disp_dest_i].tag  = disp_tag_i;
        end
    end

    // Rename state register; reset leaves every register architectural.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rename_q[i] <= '0;
            end
        end else begin
            rename_q <= rename_d;
        end
    end

    // Combinational lookups from registered state only.
    always_comb begin
        src_busy_o = rename_q[src_reg_i].busy;
        src_tag_o  = rename_q[src_reg_i].tag;
        chk_busy_o = rename_q[chk_reg_i].busy;
        chk_tag_o  = rename_q[chk_reg_i].tag;
    end

endmodule

// File: rtl/rob_dispatch_writeback.sv
// Reorder buffer producer side: tail allocation on dispatch, CDB result
// capture, head presentation to commit, and rename table ownership.
module rob_dispatch_writeback
    import rob_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               disp_valid,
    output logic               disp_ready,
    input  logic [INSTR_W-1:0] disp_instr,
    input  logic [REG_AW-1:0]  disp_dest,
    output logic [TAG_W-1:0]   disp_tag,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [DATA_W-1:0]  cdb_value,
    input  logic [REG_AW-1:0]  src_reg,
    output logic               src_busy,
    output logic [TAG_W-1:0]   src_tag,
    output logic               src_done,
    output logic [DATA_W-1:0]  src_value,
    output logic               head_valid,
    output logic [TAG_W-1:0]   head_tag,
    output logic [REG_AW-1:0]  head_dest,
    output logic [DATA_W-1:0]  head_value,
    output logic [INSTR_W-1:0] head_instr,
    output logic               head_is_last,
    input  logic               commit_ack,
    output logic [TAG_W:0]     rob_count
);

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(ROB_DEPTH);

    rob_entry_t       rob_q [ROB_DEPTH];
    rob_entry_t       rob_d [ROB_DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic             disp_fire;
    logic             commit_fire;
    logic             cdb_fire;
    logic             chk_busy;
    logic [TAG_W-1:0] chk_tag;

    // Handshake decode; disp_ready looks only at the registered count, so a
    // commit in the same cycle cannot make room for a dispatch.
    always_comb begin
        disp_ready   = (count_q != FULL_COUNT);
        disp_fire    = disp_valid & disp_ready;
        head_valid   = rob_q[head_q].alloc & rob_q[head_q].done;
        commit_fire  = commit_ack & head_valid;
        cdb_fire     = cdb_valid & rob_q[cdb_tag].alloc & ~rob_q[cdb_tag].done;
        head_is_last = chk_busy & (chk_tag == head_q);
    end

    // Entry array and pointer next-state. Dispatch only targets a free slot,
    // and commit only retires a done entry, so the three writes never collide.
    always_comb begin
        rob_d   = rob_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (cdb_fire) begin
            rob_d[cdb_tag].value = cdb_value;
            rob_d[cdb_tag].done  = 1'b1;
        end
        if (commit_fire) begin
            rob_d[head_q].alloc = 1'b0;
            rob_d[head_q].done  = 1'b0;
            head_d              = ptr_inc(head_q);
        end
        if (disp_fire) begin
            rob_d[tail_q].alloc = 1'b1;
            rob_d[tail_q].done  = 1'b0;
            rob_d[tail_q].instr = disp_instr;
            rob_d[tail_q].dest  = disp_dest;
            rob_d[tail_q].value = '0;
            tail_d              = ptr_inc(tail_q);
        end
        case ({disp_fire, commit_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // ROB state register; reset drops every entry at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            rob_q   <= rob_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    rob_rename_table u_rename (
        .clk         (clk),
        .rst         (rst),
        .disp_we_i   (disp_fire),
        .disp_dest_i (disp_dest),
        .disp_tag_i  (tail_q),
        .clr_we_i    (commit_fire & head_is_last),
        .clr_reg_i   (rob_q[head_q].dest),
        .src_reg_i   (src_reg),
        .src_busy_o  (src_busy),
        .src_tag_o   (src_tag),
        .chk_reg_i   (rob_q[head_q].dest),
        .chk_busy_o  (chk_busy),
        .chk_tag_o   (chk_tag)
    );

    // Output views of registered state.
    always_comb begin
        disp_tag   = tail_q;
        src_done   = rob_q[src_tag].done;
        src_value  = rob_q[src_tag].value;
        head_tag   = head_q;
        head_dest  = rob_q[head_q].dest;
        head_value = rob_q[head_q].value;
        head_instr = rob_q[head_q].instr;
        rob_count  = count_q;
    end

endmodule
